// File: rtl/dot_job_scheduler.sv
// Round-robin job scheduler sharing one dot-product engine between NUM_REQ requesters.
// One job in flight: grant, start pulse, wait for reading/writer done (with timeout), completion pulse.
module dot_job_scheduler #(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 5,
   parameter int MEM3_ADDR_WIDTH = 4,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_base_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          eng_start_o,
   output logic [ADDR_WIDTH-1:0]         eng_base_o,
   output logic [MEM3_ADDR_WIDTH-1:0]    eng_slot_o,
   input  logic                          eng_reading_done_i,
   input  logic                          eng_writer_done_i,
   output logic [NUM_REQ-1:0]            cpl_valid_o,
   output logic [MEM3_ADDR_WIDTH-1:0]    cpl_slot_o,
   output logic                          cpl_error_o,
   output logic                          busy_o
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT_READ,
      WAIT_WRITE,
      COMPLETE
   } state_t;

   state_t                     state_q, state_d;
   logic [IDX_W-1:0]           lastGrant_q, lastGrant_d;
   logic [IDX_W-1:0]           owner_q, owner_d;
   logic [ADDR_WIDTH-1:0]      base_q, base_d;
   logic [MEM3_ADDR_WIDTH-1:0] slot_q, slot_d;
   logic [TO_W-1:0]            timeout_q, timeout_d;
   logic                       err_q, err_d;

   logic                       engStart_q;
   logic [NUM_REQ-1:0]         cplValid_q, cplValid_d;
   logic [MEM3_ADDR_WIDTH-1:0] cplSlot_q;
   logic                       cplError_q;
   logic                       busy_q;

   logic [IDX_W-1:0]           cand;
   logic [IDX_W-1:0]           grantIdx;
   logic                       grantFound;

   // Search starts just after the last winner and wraps, so the first hit is the fair choice.
   always_comb begin
      cand       = lastGrant_q;
      grantIdx   = '0;
      grantFound = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (cand == LAST_IDX) begin
            cand = '0;
         end else begin
            cand = cand + 1'b1;
         end
         if (!grantFound && req_valid_i[cand]) begin
            grantFound = 1'b1;
            grantIdx   = cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_ready_o[i] = (state_q == IDLE) && grantFound && (grantIdx == IDX_W'(i));
      end
   end

   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      owner_d     = owner_q;
      base_d      = base_q;
      slot_d      = slot_q;
      timeout_d   = timeout_q;
      err_d       = err_q;
      case (state_q)
         IDLE: begin
            if (grantFound) begin
               owner_d     = grantIdx;
               lastGrant_d = grantIdx;
               base_d      = req_base_i[grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
               state_d     = START;
            end
         end
         START: begin
            timeout_d = '0;
            err_d     = 1'b0;
            state_d   = WAIT_READ;
         end
         WAIT_READ: begin
            timeout_d = timeout_q + 1'b1;
            if (eng_reading_done_i && eng_writer_done_i) begin
               state_d = COMPLETE;
            end else if (eng_reading_done_i) begin
               state_d = WAIT_WRITE;
            end else if (timeout_q == TO_LIMIT) begin
               err_d   = 1'b1;
               state_d = COMPLETE;
            end
         end
         WAIT_WRITE: begin
            timeout_d = timeout_q + 1'b1;
            if (eng_writer_done_i) begin
               state_d = COMPLETE;
            end else if (timeout_q == TO_LIMIT) begin
               err_d   = 1'b1;
               state_d = COMPLETE;
            end
         end
         COMPLETE: begin
            // A timed-out job leaves its slot free for the next job.
            if (!err_q) begin
               slot_d = slot_q + 1'b1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         cplValid_d[i] = (state_d == COMPLETE) && (owner_d == IDX_W'(i));
      end
   end

   // Outputs are registered from the next-state decode so they line up with the state they describe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         lastGrant_q <= LAST_IDX;
         owner_q     <= '0;
         base_q      <= '0;
         slot_q      <= '0;
         timeout_q   <= '0;
         err_q       <= 1'b0;
         engStart_q  <= 1'b0;
         cplValid_q  <= '0;
         cplSlot_q   <= '0;
         cplError_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         owner_q     <= owner_d;
         base_q      <= base_d;
         slot_q      <= slot_d;
         timeout_q   <= timeout_d;
         err_q       <= err_d;
         engStart_q  <= (state_d == START);
         cplValid_q  <= cplValid_d;
         cplError_q  <= (state_d == COMPLETE) && err_d;
         busy_q      <= (state_d != IDLE);
         if (state_d == COMPLETE) begin
            cplSlot_q <= slot_q;
         end
      end
   end

   assign eng_start_o = engStart_q;
   assign eng_base_o  = base_q;
   assign eng_slot_o  = slot_q;
   assign cpl_valid_o = cplValid_q;
   assign cpl_slot_o  = cplSlot_q;
   assign cpl_error_o = cplError_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_dot_job_scheduler.sv
// Directed bench for dot_job_scheduler: single job, contention, timeout, same-cycle dones,
// slot wrap and reset mid-job, each with hand-computed expected values.
module tb_dot_job_scheduler;

   localparam int NUM_REQ = 2;
   localparam int AW      = 5;
   localparam int SW      = 4;
   localparam int TMO     = 16;

   logic               clk = 1'b0;
   logic               rst;
   logic [NUM_REQ-1:0] reqValid;
   logic [NUM_REQ*AW-1:0] reqBase;
   logic [NUM_REQ-1:0] reqReady;
   logic               engStart;
   logic [AW-1:0]      engBase;
   logic [SW-1:0]      engSlot;
   logic               rdDone;
   logic               wrDone;
   logic [NUM_REQ-1:0] cplValid;
   logic [SW-1:0]      cplSlot;
   logic               cplError;
   logic               busy;

   int                 checkCount = 0;
   int                 passCount  = 0;
   logic [SW-1:0]      expSlot;

   always #5 clk = ~clk;

   dot_job_scheduler #(
      .NUM_REQ         (NUM_REQ),
      .ADDR_WIDTH      (AW),
      .MEM3_ADDR_WIDTH (SW),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk_i              (clk),
      .rst_i              (rst),
      .req_valid_i        (reqValid),
      .req_base_i         (reqBase),
      .req_ready_o        (reqReady),
      .eng_start_o        (engStart),
      .eng_base_o         (engBase),
      .eng_slot_o         (engSlot),
      .eng_reading_done_i (rdDone),
      .eng_writer_done_i  (wrDone),
      .cpl_valid_o        (cplValid),
      .cpl_slot_o         (cplSlot),
      .cpl_error_o        (cplError),
      .busy_o             (busy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetOutputs;
      checkOutput("rst_req_ready", 32'(reqReady), 32'd0);
      checkOutput("rst_eng_start", 32'(engStart), 32'd0);
      checkOutput("rst_eng_base", 32'(engBase), 32'd0);
      checkOutput("rst_eng_slot", 32'(engSlot), 32'd0);
      checkOutput("rst_cpl_valid", 32'(cplValid), 32'd0);
      checkOutput("rst_cpl_slot", 32'(cplSlot), 32'd0);
      checkOutput("rst_cpl_error", 32'(cplError), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
   endtask

   task automatic applyReset;
      rst      = 1'b1;
      reqValid = '0;
      rdDone   = 1'b0;
      wrDone   = 1'b0;
      tick;
      tick;
      checkResetOutputs;
      rst     = 1'b0;
      expSlot = '0;
   endtask

   // Handshake in the current cycle, then model the engine: reading_done readDly cycles after
   // start, writer_done writeDly cycles later (0 means both dones together).
   task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input int owner,
                                input logic [AW-1:0] expBase, input int readDly,
                                input int writeDly, input bit dropAfter);
      reqValid = valid;
      #1;
      checkOutput("grant", 32'(reqReady), 32'd1 << owner);
      tick;
      if (dropAfter) reqValid = '0;
      checkOutput("eng_start", 32'(engStart), 32'd1);
      checkOutput("eng_base", 32'(engBase), 32'(expBase));
      checkOutput("eng_slot", 32'(engSlot), 32'(expSlot));
      checkOutput("ready_busy", 32'(reqReady), 32'd0);
      tick;
      checkOutput("start_pulse_end", 32'(engStart), 32'd0);
      repeat (readDly - 1) tick;
      rdDone = 1'b1;
      if (writeDly == 0) wrDone = 1'b1;
      tick;
      rdDone = 1'b0;
      wrDone = 1'b0;
      if (writeDly > 0) begin
         repeat (writeDly - 1) tick;
         wrDone = 1'b1;
         tick;
         wrDone = 1'b0;
      end
      checkOutput("cpl_valid", 32'(cplValid), 32'd1 << owner);
      checkOutput("cpl_slot", 32'(cplSlot), 32'(expSlot));
      checkOutput("cpl_error", 32'(cplError), 32'd0);
      expSlot = expSlot + 1'b1;
      tick;
      checkOutput("cpl_pulse_end", 32'(cplValid), 32'd0);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("slot_next", 32'(engSlot), 32'(expSlot));
   endtask

   initial begin
      reqBase = {5'd4, 5'd0};
      applyReset;

      // Single job
      applyStimulus(2'b01, 0, 5'd0, 6, 2, 1'b1);

      // Contention: both held, minimum turnaround with same-cycle dones
      applyReset;
      for (int j = 0; j < 4; j++) begin
         applyStimulus(2'b11, j % 2, (j % 2) ? 5'd4 : 5'd0, 1, 0, 1'b0);
      end
      reqValid = '0;

      // Timeout: reading_done never arrives
      reqValid = 2'b01;
      #1;
      checkOutput("tmo_grant", 32'(reqReady), 32'd1);
      tick;
      reqValid = '0;
      checkOutput("tmo_start", 32'(engStart), 32'd1);
      repeat (TMO) tick;
      checkOutput("tmo_not_early", 32'(cplValid), 32'd0);
      tick;
      checkOutput("tmo_cpl_valid", 32'(cplValid), 32'd1);
      checkOutput("tmo_cpl_error", 32'(cplError), 32'd1);
      checkOutput("tmo_cpl_slot", 32'(cplSlot), 32'(expSlot));
      tick;
      checkOutput("tmo_idle", 32'(busy), 32'd0);
      checkOutput("tmo_slot_kept", 32'(engSlot), 32'(expSlot));
      checkOutput("tmo_error_clear", 32'(cplError), 32'd0);

      // Good job after the timeout reuses the slot; then a same-cycle-dones job after a delay
      applyStimulus(2'b10, 1, 5'd4, 2, 3, 1'b1);
      applyStimulus(2'b01, 0, 5'd0, 3, 0, 1'b1);

      // Slot wrap over 17 jobs
      applyReset;
      for (int j = 0; j < 17; j++) begin
         applyStimulus(2'b01, 0, 5'd0, 1, 0, 1'b0);
      end
      reqValid = '0;

      // Reset in WAIT_WRITE
      reqValid = 2'b10;
      #1;
      checkOutput("mid_grant", 32'(reqReady), 32'd2);
      tick;
      reqValid = '0;
      tick;
      rdDone = 1'b1;
      tick;
      rdDone = 1'b0;
      checkOutput("mid_busy", 32'(busy), 32'd1);
      rst    = 1'b1;
      wrDone = 1'b1;
      tick;
      checkResetOutputs;
      rst    = 1'b0;
      wrDone = 1'b0;
      tick;
      checkOutput("mid_no_cpl", 32'(cplValid), 32'd0);
      expSlot = '0;
      applyStimulus(2'b11, 0, 5'd0, 1, 0, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
